// File: rtl/ahb_sram_slave.sv
// AHB responder in front of a 32-bit on-chip SRAM word array.
// Supports programmable wait states, byte-lane writes, read-after-write forwarding and a two-cycle ERROR response.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

// state  | meaning
// IDLE_S | ready: no transfer, or the final cycle of a data phase
// WAIT_S | data phase stalled, counting down the wait states
// ERR1_S | first ERROR cycle, HREADYOUT low
// ERR2_S | second ERROR cycle, HREADYOUT high
module ahb_sram_slave #(
   parameter int MEM_DEPTH   = 1024,
   parameter int AW          = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic                       HSEL,
   input  logic [`AHB_ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]                 HTRANS,
   input  logic                       HWRITE,
   input  logic [2:0]                 HSIZE,
   input  logic [`AHB_DATA_WIDTH-1:0] HWDATA,
   input  logic                       HREADY,
   output logic                       HREADYOUT,
   output logic [1:0]                 HRESP,
   output logic [`AHB_DATA_WIDTH-1:0] HRDATA
);

   typedef enum logic [1:0] {IDLE_S, WAIT_S, ERR1_S, ERR2_S} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_wait_cnt;
   logic [2:0]    w_wait_cnt_nxt;
   logic          r_wr_pend;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_lane;
   logic [31:0]   r_rdata;
   logic [31:0]   r_mem [MEM_DEPTH];

   logic          w_ready;
   logic          w_accept;
   logic          w_illegal;
   logic          w_mem_we;
   logic          w_fwd;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_lane;
   logic [31:0]   w_rd_word;
   logic          w_unused;

   assign w_unused  = &{1'b0, HADDR[`AHB_ADDR_WIDTH-1:AW+2], HTRANS[0]};

   assign w_ready   = (r_state == IDLE_S) || (r_state == ERR2_S);
   assign w_accept  = HSEL && HREADY && HTRANS[1] && w_ready;
   assign w_idx     = HADDR[AW+1:2];
   assign w_illegal = (HSIZE > 3'b010)
                    || ((HSIZE == 3'b001) && HADDR[0])
                    || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
   // The pending write retires on the edge that ends its data phase.
   assign w_mem_we  = r_wr_pend && w_ready;
   assign w_fwd     = w_mem_we && (r_addr == w_idx);

   always_comb begin
      w_lane = 4'b1111;
      case (HSIZE)
         3'b000:  w_lane = 4'b0001 << HADDR[1:0];
         3'b001:  w_lane = HADDR[1] ? 4'b1100 : 4'b0011;
         default: w_lane = 4'b1111;
      endcase
   end

   always_comb begin
      w_rd_word = r_mem[w_idx];
      if (w_fwd) begin
         for (int b = 0; b < 4; b++) begin
            if (r_lane[b]) w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         IDLE_S, ERR2_S: begin
            w_state_nxt = IDLE_S;
            if (w_accept) begin
               if (w_illegal) begin
                  w_state_nxt = ERR1_S;
               end else if (WAIT_STATES != 0) begin
                  w_state_nxt    = WAIT_S;
                  w_wait_cnt_nxt = 3'(WAIT_STATES - 1);
               end
            end
         end
         WAIT_S: begin
            if (r_wait_cnt == 3'd0) w_state_nxt = IDLE_S;
            else                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
         end
         ERR1_S:  w_state_nxt = ERR2_S;
         default: w_state_nxt = IDLE_S;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= IDLE_S;
         r_wait_cnt <= 3'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wr_pend <= 1'b0;
         r_addr    <= '0;
         r_lane    <= 4'b0000;
         r_rdata   <= 32'd0;
      end else begin
         if (w_ready) r_wr_pend <= w_accept && HWRITE && !w_illegal;
         if (w_accept) begin
            r_addr <= w_idx;
            r_lane <= w_lane;
         end
         if (w_accept && !HWRITE && !w_illegal) r_rdata <= w_rd_word;
      end
   end

   // Array contents are deliberately left out of reset.
   always_ff @(posedge HCLK) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (r_lane[b]) r_mem[r_addr][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HREADYOUT = w_ready;
   assign HRESP     = ((r_state == ERR1_S) || (r_state == ERR2_S)) ? 2'b01 : 2'b00;
   assign HRDATA    = r_rdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 1 and 3 wait states) driven by a pipelined master
// and checked against a transfer-level memory model.
module tb_ahb_sram_slave;

   localparam int NI = 3;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   logic        hclk = 1'b0;
   logic        rst_n  [NI];
   logic        hsel   [NI];
   logic [31:0] haddr  [NI];
   logic [1:0]  htrans [NI];
   logic        hwrite [NI];
   logic [2:0]  hsize  [NI];
   logic [31:0] hwdata [NI];
   wire         hreadyout [NI];
   wire  [1:0]  hresp     [NI];
   wire  [31:0] hrdata    [NI];

   logic [31:0] mdl_mem [NI][1024];
   logic [31:0] last_rd [NI];
   xfer_t       q [$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 hclk = ~hclk;

   genvar g;
   generate
      for (g = 0; g < NI; g++) begin : g_dut
         ahb_sram_slave #(
            .MEM_DEPTH   (1024),
            .AW          (10),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 1 : 3)
         ) u_dut (
            .HCLK      (hclk),
            .HRESETn   (rst_n[g]),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HTRANS    (htrans[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HWDATA    (hwdata[g]),
            .HREADY    (hreadyout[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g])
         );
      end
   endgenerate

   function automatic int ws_of(input int k);
      case (k)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 1024);
   endfunction

   function automatic bit is_legal(input xfer_t x);
      return (x.size <= 3'd2) && ((x.addr % (32'd1 << x.size)) == 0);
   endfunction

   function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                                input logic wr, input logic [2:0] sz, input logic [31:0] wd);
      xfer_t x;
      x.sel = sel; x.trans = tr; x.addr = a; x.wr = wr; x.size = sz; x.wdata = wd;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic apply_write(input int k, input xfer_t x);
      int wi, lo, nb;
      wi = widx(x.addr);
      nb = 1 << x.size;
      lo = int'(x.addr % 4);
      for (int b = lo; b < lo + nb; b++) mdl_mem[k][wi][8*b +: 8] = x.wdata[8*b +: 8];
   endtask

   task automatic drive(input int k, input xfer_t x);
      hsel[k]   = x.sel;
      htrans[k] = x.trans;
      haddr[k]  = x.addr;
      hwrite[k] = x.wr;
      hsize[k]  = x.size;
   endtask

   task automatic drive_idle(input int k);
      drive(k, mk(1'b1, 2'b00, $urandom, 1'($urandom), 3'($urandom), 32'd0));
   endtask

   // Pipelined master: address phase of the head of q overlaps the current data phase.
   task automatic run_seq(input int k);
      xfer_t dp;
      bit    dp_v, dp_ok, rdy;
      int    dp_c, stall;
      dp_v = 0; dp_ok = 0; dp_c = 0; stall = 0;
      while (q.size() > 0 || dp_v) begin
         if (q.size() > 0) drive(k, q[0]);
         else              drive_idle(k);
         hwdata[k] = dp_v ? dp.wdata : $urandom;
         @(negedge hclk);
         if (dp_v && dp_ok) begin
            chk($sformatf("i%0d_rdy", k), 32'(hreadyout[k]), 32'(dp_c >= ws_of(k)));
            chk($sformatf("i%0d_resp", k), 32'(hresp[k]), 32'd0);
         end else if (dp_v) begin
            chk($sformatf("i%0d_err_rdy", k), 32'(hreadyout[k]), 32'(dp_c >= 1));
            chk($sformatf("i%0d_err_resp", k), 32'(hresp[k]), 32'd1);
         end else begin
            chk($sformatf("i%0d_idle_rdy", k), 32'(hreadyout[k]), 32'd1);
            chk($sformatf("i%0d_idle_resp", k), 32'(hresp[k]), 32'd0);
         end
         chk($sformatf("i%0d_rdata", k), hrdata[k], last_rd[k]);
         rdy = (hreadyout[k] === 1'b1);
         @(posedge hclk);
         #1;
         if (rdy) begin
            stall = 0;
            if (dp_v && dp_ok && dp.wr) apply_write(k, dp);
            dp_v = 0;
            if (q.size() > 0) begin
               dp = q.pop_front();
               if (dp.sel && dp.trans[1]) begin
                  dp_v  = 1;
                  dp_c  = 0;
                  dp_ok = is_legal(dp);
                  if (dp_ok && !dp.wr) last_rd[k] = mdl_mem[k][widx(dp.addr)];
               end
            end
         end else begin
            dp_c++;
            stall++;
            if (stall > 12) begin
               chk($sformatf("i%0d_timeout", k), 32'(stall), 32'd0);
               q.delete();
               break;
            end
         end
      end
      drive_idle(k);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r, off;
      logic [2:0]  sz;

      for (int k = 0; k < NI; k++) begin
         rst_n[k]   = 1'b0;
         hwdata[k]  = 32'd0;
         last_rd[k] = 32'd0;
         drive_idle(k);
      end
      repeat (2) @(posedge hclk);
      #1;
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

      // Idle bus after reset.
      repeat (5) begin
         @(negedge hclk);
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d_rst_rdy", k), 32'(hreadyout[k]), 32'd1);
            chk($sformatf("i%0d_rst_resp", k), 32'(hresp[k]), 32'd0);
            chk($sformatf("i%0d_rst_rdata", k), hrdata[k], 32'd0);
         end
      end
      @(posedge hclk);
      #1;

      // Preload words 0..31 of every instance.
      for (int k = 0; k < NI; k++) begin
         for (int w = 0; w < 32; w++)
            q.push_back(mk(1'b1, (w == 0) ? 2'b10 : 2'b11, 32'(w * 4), 1'b1, 3'd2, $urandom));
         run_seq(k);
      end

      // One wait state: word write then read of the same word.
      q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
      q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'd0));
      run_seq(1);
      @(negedge hclk);
      chk("ws1_wr_rd", hrdata[1], 32'hDEADBEEF);
      @(posedge hclk); #1;

      // Zero wait states: byte write forwarded into a back-to-back read.
      q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b1, 3'd2, 32'h11223344));
      q.push_back(mk(1'b1, 2'b10, 32'h21, 1'b1, 3'd0, 32'h0000AA00));
      q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'd0));
      run_seq(0);
      @(negedge hclk);
      chk("ws0_fwd", hrdata[0], 32'h1122AA44);
      @(posedge hclk); #1;

      // Misaligned halfword write errors out and leaves the word intact.
      q.push_back(mk(1'b1, 2'b10, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D));
      q.push_back(mk(1'b1, 2'b10, 32'h33, 1'b1, 3'd1, 32'h12345678));
      q.push_back(mk(1'b1, 2'b10, 32'h30, 1'b0, 3'd2, 32'd0));
      run_seq(1);
      @(negedge hclk);
      chk("err_nowrite", hrdata[1], 32'hCAFEF00D);
      @(posedge hclk); #1;

      // Three wait states: NONSEQ read followed by SEQ read.
      q.push_back(mk(1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'd0));
      q.push_back(mk(1'b1, 2'b11, 32'h44, 1'b0, 3'd2, 32'd0));
      run_seq(2);

      // Reset during the wait states of a write abandons it.
      q.push_back(mk(1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 32'h0BADCAFE));
      run_seq(2);
      drive(2, mk(1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 32'd0));
      @(posedge hclk); #1;
      drive_idle(2);
      hwdata[2] = 32'h55555555;
      @(negedge hclk);
      chk("rst_in_wait", 32'(hreadyout[2]), 32'd0);
      rst_n[2] = 1'b0;
      #1;
      chk("rst_async_rdy", 32'(hreadyout[2]), 32'd1);
      chk("rst_async_resp", 32'(hresp[2]), 32'd0);
      chk("rst_async_rdata", hrdata[2], 32'd0);
      @(posedge hclk); #1;
      rst_n[2]   = 1'b1;
      last_rd[2] = 32'd0;
      q.push_back(mk(1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'd0));
      run_seq(2);
      @(negedge hclk);
      chk("rst_old_word", hrdata[2], 32'h0BADCAFE);
      @(posedge hclk); #1;

      // Randomized traffic with address wrap, idles, BUSY, deselects and illegal accesses.
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 80; i++) begin
            r = $urandom_range(99);
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(31)) << 2);
            if (r < 10) begin
               q.push_back(mk(1'b1, 2'b00, a, 1'($urandom), 3'd2, $urandom));
            end else if (r < 15) begin
               q.push_back(mk(1'b1, 2'b01, a, 1'($urandom), 3'd2, $urandom));
            end else if (r < 20) begin
               q.push_back(mk(1'b0, 2'b10, a, 1'($urandom), 3'd2, $urandom));
            end else begin
               sz  = (r < 26) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
               off = $urandom_range(3);
               if (sz == 3'd1 && $urandom_range(3) != 0) off = off & 2;
               if (sz == 3'd2 && $urandom_range(3) != 0) off = 0;
               q.push_back(mk(1'b1, $urandom_range(1) ? 2'b10 : 2'b11, a | 32'(off),
                              1'($urandom), sz, $urandom));
            end
         end
         run_seq(k);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
